// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encoding and default widths for seq_divider
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Same operand widths as the small DSP multiplier this divider inverts
  localparam int DEF_DIVISOR_BITS  = 4;
  localparam int DEF_DIVIDEND_BITS = 8;

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division iteration
module seq_divider_div_step #(
  parameter int DIVISOR_BITS = 4
) (
  input  logic [DIVISOR_BITS:0]   i_rem,
  input  logic                    i_bit,
  input  logic [DIVISOR_BITS-1:0] i_divisor,
  output logic [DIVISOR_BITS:0]   o_rem,
  output logic                    o_q_bit
);

  logic [DIVISOR_BITS+1:0] w_shifted;
  logic [DIVISOR_BITS+1:0] w_trial;
  logic                    w_ge;

  assign w_shifted = {i_rem, i_bit};
  assign w_trial   = w_shifted - {2'b00, i_divisor};
  assign w_ge      = (w_shifted >= {2'b00, i_divisor});

  // Remainder stays below the divisor, so truncation to DIVISOR_BITS+1 is lossless
  assign o_rem   = (DIVISOR_BITS + 1)'(w_ge ? w_trial : w_shifted);
  assign o_q_bit = w_ge;

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, one quotient bit per cycle
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVISOR_BITS  = DEF_DIVISOR_BITS,
  parameter int DIVIDEND_BITS = DEF_DIVIDEND_BITS
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [DIVIDEND_BITS-1:0] i_dividend,
  input  logic [DIVISOR_BITS-1:0]  i_divisor,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [DIVIDEND_BITS-1:0] o_quotient,
  output logic [DIVISOR_BITS-1:0]  o_remainder,
  output logic                     o_div_by_zero
);

  localparam int CW = (DIVIDEND_BITS > 1) ? $clog2(DIVIDEND_BITS) : 1;

  div_state_t               r_state;
  div_state_t               w_state_next;
  logic [CW-1:0]            r_count;
  logic [DIVIDEND_BITS-1:0] r_shift;
  logic [DIVISOR_BITS-1:0]  r_divisor;
  logic [DIVISOR_BITS:0]    r_rem;
  logic [DIVISOR_BITS:0]    w_rem_next;
  logic                     w_q_bit;
  logic [DIVIDEND_BITS-1:0] w_shift_next;
  logic                     w_last;

  seq_divider_div_step #(
    .DIVISOR_BITS(DIVISOR_BITS)
  ) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_shift[DIVIDEND_BITS-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  // Dividend bits leave at the MSB while quotient bits enter at the LSB
  assign w_shift_next = (r_shift << 1) | DIVIDEND_BITS'(w_q_bit);
  assign w_last       = (r_count == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_in_valid) w_state_next = (i_divisor == '0) ? ST_DONE : ST_BUSY;
      ST_BUSY: if (w_last)     w_state_next = ST_DONE;
      ST_DONE: if (i_out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = (r_state == ST_IDLE);
    o_out_valid = (r_state == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count       <= '0;
      r_shift       <= '0;
      r_divisor     <= '0;
      r_rem         <= '0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_in_valid) begin
          r_shift   <= i_dividend;
          r_divisor <= i_divisor;
          r_rem     <= '0;
          if (i_divisor == '0) begin
            o_quotient    <= '1;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b1;
          end else begin
            r_count <= CW'(DIVIDEND_BITS - 1);
          end
        end
        ST_BUSY: begin
          r_shift <= w_shift_next;
          r_rem   <= w_rem_next;
          r_count <= r_count - 1'b1;
          if (w_last) begin
            o_quotient    <= w_shift_next;
            o_remainder   <= w_rem_next[DIVISOR_BITS-1:0];
            o_div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
